// File: rtl/gumnut_port_responder.sv
// Gumnut I/O port responder: four 8-bit registers, wait-stated ack, prescaled interrupt timer.
// Optional CTRL.OVR overrun flag enabled by defining GUMNUT_PORT_OVERRUN_EN.
module gumnut_port_responder #(
  parameter logic [7:0]  BASE_ADDR   = 8'h00,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned PRESCALE    = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       port_cyc_i,
  input  logic       port_stb_i,
  input  logic       port_we_i,
  input  logic [7:0] port_adr_i,
  input  logic [7:0] port_dat_i,
  output logic [7:0] port_dat_o,
  output logic       port_ack_o,
  output logic       int_req_o,
  input  logic       int_ack_i,
  input  logic [7:0] gpio_in_i,
  output logic [7:0] gpio_out_o
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  localparam int            PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);
  localparam logic [3:0]    WS        = 4'(WAIT_STATES);

  localparam logic [1:0] OFS_GPIO_OUT = 2'd0;
  localparam logic [1:0] OFS_GPIO_IN  = 2'd1;
  localparam logic [1:0] OFS_RELOAD   = 2'd2;
  localparam logic [1:0] OFS_CTRL     = 2'd3;

  state_t        state_q, state_d;
  logic [3:0]    wcnt_q;
  logic [1:0]    adr_q;
  logic          we_q;
  logic [7:0]    dat_q;
  logic          req;
  logic          wr_commit;
  logic          rd_load;

  logic [7:0]    gpio_sync1_q, gpio_sync2_q;
  logic [7:0]    reload_q;
  logic [7:0]    count_q;
  logic [PW-1:0] presc_q;
  logic          ten_q, ien_q, pend_q, ovr_q;
  logic          tick, expire, wr_reload, wr_ctrl, pend_clr;
  logic [7:0]    rd_mux;

  assign req = port_cyc_i & port_stb_i & (port_adr_i[7:2] == BASE_ADDR[7:2]);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // NOTE: default assignment first keeps this combinational block from inferring a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (req) state_d = S_WAIT;
      S_WAIT: begin
        if (!req)              state_d = S_IDLE;
        else if (wcnt_q == '0) state_d = S_ACK;
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    port_ack_o = (state_q == S_ACK);
    wr_commit  = (state_q == S_ACK) && we_q;
    rd_load    = (state_q == S_WAIT) && req && (wcnt_q == '0) && !we_q;
  end

  // Request capture: the transfer is defined by what the core presented when first seen.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wcnt_q <= '0;
      adr_q  <= '0;
      we_q   <= 1'b0;
      dat_q  <= '0;
    end else if (state_q == S_IDLE && req) begin
      wcnt_q <= WS;
      adr_q  <= port_adr_i[1:0];
      we_q   <= port_we_i;
      dat_q  <= port_dat_i;
    end else if (state_q == S_WAIT && wcnt_q != '0) begin
      wcnt_q <= wcnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      gpio_sync1_q <= '0;
      gpio_sync2_q <= '0;
    end else begin
      gpio_sync1_q <= gpio_in_i;
      gpio_sync2_q <= gpio_sync1_q;
    end
  end

  assign wr_reload = wr_commit && (adr_q == OFS_RELOAD);
  assign wr_ctrl   = wr_commit && (adr_q == OFS_CTRL);
  assign tick      = ten_q && (presc_q == PRESC_MAX);
  assign expire    = tick && (count_q == '0);
  assign int_req_o = pend_q & ien_q;
  assign pend_clr  = (int_ack_i && int_req_o) || (wr_ctrl && dat_q[7]);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      gpio_out_o <= '0;
      reload_q   <= 8'hFF;
      ten_q      <= 1'b0;
      ien_q      <= 1'b0;
    end else if (wr_commit) begin
      case (adr_q)
        OFS_GPIO_OUT: gpio_out_o <= dat_q;
        OFS_RELOAD:   reload_q   <= dat_q;
        OFS_CTRL: begin
          ten_q <= dat_q[0];
          ien_q <= dat_q[1];
        end
        default: ;
      endcase
    end
  end

  // A RELOAD write overrides any coincident tick on count and prescaler.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= 8'hFF;
      presc_q <= '0;
    end else if (wr_reload) begin
      count_q <= dat_q;
      presc_q <= '0;
    end else if (ten_q) begin
      presc_q <= tick ? '0 : presc_q + PW'(1);
      if (tick) count_q <= (count_q == '0) ? reload_q : count_q - 8'd1;
    end
  end

  // Expiry takes priority over any clear arriving on the same edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)         pend_q <= 1'b0;
    else if (expire)   pend_q <= 1'b1;
    else if (pend_clr) pend_q <= 1'b0;
  end

`ifdef GUMNUT_PORT_OVERRUN_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                    ovr_q <= 1'b0;
    else if (expire && pend_q)    ovr_q <= 1'b1;
    else if (wr_ctrl && dat_q[6]) ovr_q <= 1'b0;
  end
`else
  assign ovr_q = 1'b0;
`endif

  always_comb begin
    rd_mux = '0;
    case (adr_q)
      OFS_GPIO_OUT: rd_mux = gpio_out_o;
      OFS_GPIO_IN:  rd_mux = gpio_sync2_q;
      OFS_RELOAD:   rd_mux = reload_q;
      OFS_CTRL:     rd_mux = {pend_q, ovr_q, 4'b0000, ien_q, ten_q};
      default:      rd_mux = '0;
    endcase
  end

  // Read data is captured entering ACK so it is stable for the whole ack cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)        port_dat_o <= '0;
    else if (rd_load) port_dat_o <= rd_mux;
  end

endmodule

// File: tb/tb_gumnut_port_responder.sv
// Directed self-checking bench for gumnut_port_responder: two instances cover
// zero/three wait states, address decode, abort, reset and the timer/interrupt path.
module tb_gumnut_port_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic       cyc_a, stb_a, cyc_b, stb_b, we, int_ack;
  logic [7:0] adr, dat, gpio_in;
  logic [7:0] dat_a, gout_a, dat_b, gout_b;
  logic       ack_a, irq_a, ack_b, irq_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  gumnut_port_responder #(.BASE_ADDR(8'h40), .WAIT_STATES(0), .PRESCALE(4)) dut_a (
    .clk_i(clk), .rst_i(rst), .port_cyc_i(cyc_a), .port_stb_i(stb_a), .port_we_i(we),
    .port_adr_i(adr), .port_dat_i(dat), .port_dat_o(dat_a), .port_ack_o(ack_a),
    .int_req_o(irq_a), .int_ack_i(int_ack), .gpio_in_i(gpio_in), .gpio_out_o(gout_a)
  );

  gumnut_port_responder #(.BASE_ADDR(8'h00), .WAIT_STATES(3), .PRESCALE(16)) dut_b (
    .clk_i(clk), .rst_i(rst), .port_cyc_i(cyc_b), .port_stb_i(stb_b), .port_we_i(we),
    .port_adr_i(adr), .port_dat_i(dat), .port_dat_o(dat_b), .port_ack_o(ack_b),
    .int_req_o(irq_b), .int_ack_i(int_ack), .gpio_in_i(gpio_in), .gpio_out_o(gout_b)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete transfer; lat counts edges from the first edge that sees req to the ack.
  task automatic bus(input bit sel_b, input logic w, input logic [7:0] a, input logic [7:0] d,
                     output int lat, output logic [7:0] rdata);
    we = w; adr = a; dat = d;
    if (sel_b) begin cyc_b = 1'b1; stb_b = 1'b1; end
    else       begin cyc_a = 1'b1; stb_a = 1'b1; end
    lat = 0;
    step();
    while (((sel_b ? ack_b : ack_a) !== 1'b1) && lat < 50) begin
      step();
      lat++;
    end
    rdata = sel_b ? dat_b : dat_a;
    cyc_a = 1'b0; stb_a = 1'b0; cyc_b = 1'b0; stb_b = 1'b0;
    step();
    check("ack_single_cycle", sel_b ? ack_b : ack_a, 1'b0);
  endtask

  task automatic wr(input bit sel_b, input logic [7:0] a, input logic [7:0] d);
    int lat;
    logic [7:0] unused_rd;
    bus(sel_b, 1'b1, a, d, lat, unused_rd);
    check("wr_latency", lat, sel_b ? 4 : 1);
  endtask

  task automatic rd(input bit sel_b, input logic [7:0] a, input logic [7:0] expected, input string tag);
    int lat;
    logic [7:0] rdata;
    bus(sel_b, 1'b0, a, 8'h00, lat, rdata);
    check({tag, "_latency"}, lat, sel_b ? 4 : 1);
    check(tag, rdata, expected);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acks;
    logic [7:0] ctrl_ovr;
`ifdef GUMNUT_PORT_OVERRUN_EN
    ctrl_ovr = 8'h40;
`else
    ctrl_ovr = 8'h00;
`endif
    rst = 1'b1; cyc_a = 0; stb_a = 0; cyc_b = 0; stb_b = 0; we = 0;
    adr = 0; dat = 0; gpio_in = 0; int_ack = 0;
    step(); step();
    check("rst_a_outputs", {dat_a, ack_a, irq_a, gout_a}, 18'h0);
    check("rst_b_outputs", {dat_b, ack_b, irq_b, gout_b}, 18'h0);
    rst = 1'b0;
    step();

    // Asynchronous reset in the middle of a wait-stated write.
    we = 1'b1; adr = 8'h00; dat = 8'h99; cyc_b = 1'b1; stb_b = 1'b1;
    step(); step();
    rst = 1'b1;
    #1;
    check("rst_mid_ack", ack_b, 1'b0);
    check("rst_mid_gpio", gout_b, 8'h00);
    cyc_b = 1'b0; stb_b = 1'b0;
    step();
    rst = 1'b0;
    step();
    rd(1'b1, 8'h02, 8'hFF, "reload_reset");
    rd(1'b1, 8'h03, 8'h00, "ctrl_reset");
    rd(1'b1, 8'h00, 8'h00, "gpio_out_after_rst");

    // Synchronized input read, zero wait states.
    gpio_in = 8'hA5;
    step(); step(); step();
    rd(1'b0, 8'h41, 8'hA5, "gpio_in_read");

    // Three wait states: write, immediate output, readback, data hold on writes.
    wr(1'b1, 8'h00, 8'h3C);
    check("gpio_out_write", gout_b, 8'h3C);
    rd(1'b1, 8'h00, 8'h3C, "gpio_out_readback");
    wr(1'b1, 8'h02, 8'h10);
    check("dat_o_holds_on_write", dat_b, 8'h3C);

    // Strobe dropped during WAIT aborts with no side effect.
    we = 1'b1; adr = 8'h00; dat = 8'h77; cyc_b = 1'b1; stb_b = 1'b1;
    step(); step();
    stb_b = 1'b0;
    acks = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (ack_b === 1'b1) acks++;
    end
    cyc_b = 1'b0;
    check("abort_no_ack", acks, 0);
    check("abort_gpio_unchanged", gout_b, 8'h3C);
    wr(1'b1, 8'h00, 8'h5A);
    check("after_abort_write", gout_b, 8'h5A);

    // Unmatched address never acks and changes nothing.
    we = 1'b1; adr = 8'h04; dat = 8'h11; cyc_b = 1'b1; stb_b = 1'b1;
    acks = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (ack_b === 1'b1) acks++;
    end
    cyc_b = 1'b0; stb_b = 1'b0;
    step();
    check("unmatched_no_ack", acks, 0);
    rd(1'b1, 8'h00, 8'h5A, "unmatched_gpio_kept");
    wr(1'b1, 8'h01, 8'h00);
    rd(1'b1, 8'h01, 8'hA5, "gpio_in_write_ignored");

    // Timer on instance A: PRESCALE=4, RELOAD=2 -> expiry every 12 cycles.
    wr(1'b0, 8'h42, 8'h02);
    wr(1'b0, 8'h43, 8'h03);
    for (int i = 0; i < 11; i++) step();
    check("irq_before_expiry", irq_a, 1'b0);
    step();
    check("irq_first_expiry", irq_a, 1'b1);
    int_ack = 1'b1;
    step();
    int_ack = 1'b0;
    check("irq_cleared_by_ack", irq_a, 1'b0);
    for (int i = 0; i < 10; i++) step();
    check("irq_before_rearm", irq_a, 1'b0);
    step();
    check("irq_rearm", irq_a, 1'b1);
    for (int i = 0; i < 11; i++) step();
    int_ack = 1'b1;
    step();
    int_ack = 1'b0;
    check("expiry_beats_ack", irq_a, 1'b1);
    rd(1'b0, 8'h43, 8'h83 | ctrl_ovr, "ctrl_overrun");

    // Disable interrupts; int_ack with int_req low must not clear PEND.
    wr(1'b0, 8'h43, 8'h00);
    check("irq_masked", irq_a, 1'b0);
    int_ack = 1'b1;
    step();
    int_ack = 1'b0;
    rd(1'b0, 8'h43, 8'h80 | ctrl_ovr, "ctrl_ack_ignored");
    wr(1'b0, 8'h43, 8'hC0);
    rd(1'b0, 8'h43, 8'h00, "ctrl_w1c");
    rd(1'b0, 8'h42, 8'h02, "reload_readback");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gumnut_port_responder.md
Name: gumnut_port_responder

Overview:
- Responder (slave) end of the Gumnut I/O port bus.
- Decodes core port cycles into four 8-bit registers: GPIO output, synchronized GPIO input, timer reload, control/status.
- Returns port_ack_o with a configurable number of wait states.
- Owns an 8-bit prescaled down-counter timer that raises int_req_o and clears on the core's int_ack handshake.

Parameters:
- BASE_ADDR, 8'h00: port address of register 0; bits [1:0] must be 0; decode is port_adr_i[7:2] == BASE_ADDR[7:2].
- WAIT_STATES, 0: extra cycles inserted before ack (0..15).
- PRESCALE, 16: clk_i cycles per timer tick (>= 1).

Ports:
- clk_i  in  1  system clock, all logic on rising edge.
- rst_i  in  1  reset; asynchronous, active-high.
- port_cyc_i  in  1  bus cycle valid.
- port_stb_i  in  1  strobe.
- port_we_i  in  1  1 = write, 0 = read.
- port_adr_i  in  8  port address.
- port_dat_i  in  8  write data from core.
- port_dat_o  out  8  read data, registered.
- port_ack_o  out  1  transfer acknowledge, one-cycle pulse.
- int_req_o  out  1  interrupt request to core.
- int_ack_i  in  1  interrupt acknowledge from core.
- gpio_in_i  in  8  asynchronous external inputs.
- gpio_out_o  out  8  output register.

Behaviour:
- Reset values: port_ack_o=0, port_dat_o=0, int_req_o=0, gpio_out_o=0, RELOAD=8'hFF, count=8'hFF, prescaler=0, CTRL=0, pending=0, input synchronizers=0.
- req = port_cyc_i & port_stb_i & address match.
- Register map (offset = port_adr_i[1:0]):
  - 0 GPIO_OUT: r/w.
  - 1 GPIO_IN: read-only, 2-flop synchronized; writes ignored.
  - 2 RELOAD: r/w; a write also loads count and clears prescaler.
  - 3 CTRL: bit0 TEN (r/w), bit1 IEN (r/w), bit7 PEND (read; write 1 clears). Other bits read 0.
- Bus FSM:
  - IDLE: on req, latch adr/we/dat, load wait counter = WAIT_STATES, go to WAIT.
  - WAIT: if req drops, abort to IDLE (no ack, no side effect). Else if counter==0 go to ACK, else decrement.
  - ACK: port_ack_o=1 for exactly this cycle; the write commits at the ACK edge; port_dat_o holds read data during ACK; go to IDLE.
- Latency: ack is asserted WAIT_STATES+1 cycles after req first seen; a minimum of one IDLE cycle separates back-to-back transfers.
- Unmatched address: never acks; FSM stays IDLE.
- port_dat_o is updated only on reads and holds its value otherwise.
- Timer:
  - When TEN=1, the prescaler counts 0..PRESCALE-1; the wrap cycle is a tick.
  - On tick: if count==0, count<=RELOAD and PEND<=1; else count<=count-1.
  - RELOAD=0 gives expiry every tick.
  - TEN=0 freezes count and prescaler.
- Interrupt:
  - int_req_o = registered PEND & IEN.
  - int_ack_i high while int_req_o=1 clears PEND.
  - int_ack_i while int_req_o=0 is ignored.
- Simultaneous expiry and clear (int_ack_i or CTRL write-1): set wins, PEND stays 1.
- RELOAD write coincident with tick: the write wins; count=new value, no decrement.
- Asynchronous reset mid-transfer: FSM returns to IDLE, no ack, no register update.

Optional Feature:
- Macro: GUMNUT_PORT_OVERRUN_EN.
- Defined:
  - CTRL bit6 OVR sets when the timer expires while PEND=1.
  - OVR is cleared by writing 1 to bit6; it is not cleared by int_ack_i.
  - Reset value 0.
- Undefined: bit6 reads 0, no OVR logic.

Test Plan:
- Reset, then read offset 1 with gpio_in_i=8'hA5 held 3 cycles, WAIT_STATES=0 -> ack exactly 1 cycle after req, port_dat_o=8'hA5.
- Write 8'h3C to offset 0 with WAIT_STATES=3 -> ack 4 cycles after req; gpio_out_o=8'h3C from the cycle after ack; readback returns 8'h3C.
- Drop stb during WAIT (WAIT_STATES=3, write offset 0) -> no ack; gpio_out_o unchanged; next request completes normally.
- Access address BASE_ADDR+4 -> no ack for 20 cycles; registers unchanged.
- PRESCALE=4, RELOAD=2, CTRL=8'h03 -> int_req_o rises 12 cycles after the CTRL write commits; pulse int_ack_i -> int_req_o=0 next cycle, reasserts 12 cycles later.
- Expiry on the same cycle as int_ack_i -> PEND stays 1; with GUMNUT_PORT_OVERRUN_EN, OVR=1 and CTRL reads 8'hC3.
